// File: rtl/frequency_control.sv
// Sequencer ahead of the frequency rotator: registers the sample stream and
// injects coarse/fine CFO updates as tagged beats, reverting to zero on timeout/clear.
module frequency_control #(
  parameter int TIMEOUT     = 4096,
  parameter int COUNT_WIDTH = 16,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [31:0]           s_data,
  input  logic                  e_valid,
  output logic                  e_ready,
  input  logic [31:0]           e_data,
  input  logic                  e_fine,
  input  logic                  clear,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [31:0]           m_data,
  output logic [31:0]           m_user,
  output logic                  m_last,
  output logic [1:0]            state,
  output logic [DROP_WIDTH-1:0] dropped
);

  // state  | meaning
  // IDLE   | zero offset, fine estimates are dropped
  // COARSE | coarse estimate applied
  // LOCKED | coarse plus at least one fine correction applied
  typedef enum logic [1:0] {IDLE = 2'd0, COARSE = 2'd1, LOCKED = 2'd2} state_t;

  state_t                 st;
  logic                   pending;
  logic [31:0]            pend_val;
  logic [31:0]            total;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   accept_s;
  logic                   accept_e;
  logic                   timeout_hit;
  logic signed [32:0]     sum;
  logic [31:0]            sum_sat;

  assign s_ready     = !m_valid || m_ready;
  assign e_ready     = !pending && !clear;
  assign accept_s    = s_valid && s_ready;
  assign accept_e    = e_valid && e_ready;
  assign state       = st;
  assign timeout_hit = (st != IDLE) && !pending && (cnt == COUNT_WIDTH'(TIMEOUT));

  // Sign-extended add; a carry disagreeing with the sign bit means overflow.
  assign sum     = $signed({total[31], total}) + $signed({e_data[31], e_data});
  assign sum_sat = (sum[32] != sum[31]) ? (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                                        : sum[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_user   <= '0;
      m_last   <= 1'b0;
      st       <= IDLE;
      total    <= '0;
      pending  <= 1'b0;
      pend_val <= '0;
      cnt      <= '0;
      dropped  <= '0;
    end else begin
      if (accept_s) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_last  <= pending;
        m_user  <= pending ? pend_val : 32'h0;
        pending <= 1'b0;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      if (accept_s && (st != IDLE) && (cnt != COUNT_WIDTH'(TIMEOUT)))
        cnt <= cnt + 1'b1;

      // Later assignments override the datapath/counter updates above.
      if (clear) begin
        st       <= IDLE;
        total    <= '0;
        pending  <= 1'b1;
        pend_val <= '0;
        cnt      <= '0;
      end else if (accept_e) begin
        cnt <= '0;
        if (!e_fine) begin
          st       <= COARSE;
          total    <= e_data;
          pending  <= 1'b1;
          pend_val <= e_data;
        end else if (st == IDLE) begin
          if (dropped != {DROP_WIDTH{1'b1}})
            dropped <= dropped + 1'b1;
        end else begin
          st       <= LOCKED;
          total    <= sum_sat;
          pending  <= 1'b1;
          pend_val <= sum_sat;
        end
      end else if (timeout_hit) begin
        st       <= IDLE;
        total    <= '0;
        pending  <= 1'b1;
        pend_val <= '0;
        cnt      <= '0;
      end
    end
  end

endmodule

// File: doc/frequency_control.md
Name: frequency_control

Overview:
Sequencer in front of frequency_correction. It passes the complex sample stream through one register stage. It accepts carrier-frequency-offset estimates (coarse, then fine) on a side channel and combines them into a phase increment. It schedules each new increment into the stream as a tagged beat (m_last=1, m_user=increment), at which point the downstream rotator loads the frequency and zeroes its phase. It also reverts to zero offset after a sample timeout or an explicit clear.

Parameters:
TIMEOUT, 4096, accepted input samples in COARSE/LOCKED without a new estimate before reverting to IDLE; must be >= 1
COUNT_WIDTH, 16, width of timeout counter; 2**COUNT_WIDTH > TIMEOUT
DROP_WIDTH, 8, width of saturating dropped-estimate counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  input sample ready
s_data  in  32  sample, {Q[15:0], I[15:0]}
e_valid  in  1  estimate valid
e_ready  out  1  estimate ready
e_data  in  32  signed phase increment estimate
e_fine  in  1  0 = coarse estimate, 1 = fine correction
clear  in  1  single-cycle request to revert to zero offset
m_valid  out  1  output sample valid
m_ready  in  1  output sample ready
m_data  out  32  sample (s_data delayed)
m_user  out  32  frequency carried on tagged beat; 0 on untagged beats
m_last  out  1  beat carries a frequency update
state  out  2  0 IDLE, 1 COARSE, 2 LOCKED
dropped  out  DROP_WIDTH  saturating count of ignored fine estimates

Behaviour:
- Reset (synchronous, active-high): m_valid=0, m_last=0, m_user=0, m_data=0, state=IDLE, total=0, pending=0, timeout counter=0, dropped=0. Reset mid-stream discards the registered beat and any pending update.
- Datapath is one register stage. s_ready = !m_valid || m_ready. An accepted input beat appears on m_* the next cycle. m_* are held stable while m_valid && !m_ready.
- Pending update: flag plus 32-bit value. When pending=1 at the start of a cycle in which an input beat is accepted, that beat is registered with m_last=1 and m_user=value, and pending clears. Otherwise the beat is registered with m_last=0 and m_user=0.
- e_ready = !pending && !clear. Only one outstanding update exists.
- An estimate accepted in the same cycle as an input beat tags the following beat, never the concurrent one.
- Estimate handling (on e_valid && e_ready):
  - Coarse estimate in any state: total = e_data; state goes to COARSE; pending=1 with value e_data.
  - Fine estimate in COARSE or LOCKED: total = sat32(total + e_data), saturating to 0x7FFFFFFF / 0x80000000; state goes to LOCKED; pending=1 with value = new total.
  - Fine estimate in IDLE: consumed and ignored; dropped increments, saturating at its maximum value.
  - Every accepted coarse or fine estimate clears the timeout counter.
- Timeout:
  - In COARSE or LOCKED, each accepted input beat increments the counter, saturating at TIMEOUT.
  - When counter==TIMEOUT and pending==0: state goes to IDLE, total=0, pending=1 with value 0, counter=0.
  - A counter at TIMEOUT while pending=1 waits until pending clears.
  - If an estimate is accepted in the cycle the timeout would fire, the estimate wins.
- Clear: has priority over estimate and timeout. state goes to IDLE, total=0, pending=1 with value 0 (overwriting any pending value), counter=0. The estimate is not accepted that cycle because e_ready=0.
- In IDLE with nothing pending, no tagged beats are produced. A clear or timeout while already in IDLE with total 0 still produces one tagged beat with m_user=0.
- Full throughput: one beat per cycle when m_ready is held high.

Test Plan:
- Passthrough: reset, stream 0x00010002..0x00010011 with m_ready=1 -> identical m_data one cycle later, m_last=0 and m_user=0 on all beats, state=0, no bubbles.
- Coarse then fine: coarse 0x00100000, 3 samples, fine 0xFFFF0000, 3 samples -> first sample after each estimate has m_last=1. m_user=0x00100000, then 0x000F0000. state 1 then 2.
- Saturation and drop: fine 5 in IDLE -> dropped=1, no tag. Coarse 0x7FFFFF00 then fine 0x00001000 -> tag m_user=0x7FFFFFFF.
- Timeout: TIMEOUT=8, coarse 0x1234, then 8 samples -> tag 0x1234 on sample 1. The sample after the 8th is tagged m_user=0, state=0. A coarse estimate arriving on the firing cycle keeps state=1 instead.
- Backpressure: m_ready toggles 1,0,0,1 with a pending update -> m_data/m_last/m_user held while stalled, and the tag appears exactly once.
- Clear and reset: coarse pending with no samples, assert clear -> the next sample is tagged m_user=0. A reset asserted while m_valid=1 -> m_valid=0 next cycle and state=0.
